// File: rtl/jk_seq_pkg.sv
// Shared encodings for the JK sequencer: command ops, controller states and
// the J/K pair codes driven into each cell.
package jk_seq_pkg;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EXEC   = 2'b01,
    COUNT  = 2'b10,
    DONE_S = 2'b11
  } state_e;

  // Packed as {J, K}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to zero.
module jk_cell
  import jk_seq_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic r_q;

  // NOTE: clocked state is written with <= so every register samples the
  // pre-edge values of its neighbours, regardless of process ordering.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_q <= 1'b0;
    end else begin
      case (jk_e'({J, K}))
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command sequencer driving a bank of JK cells as a clearable/loadable register
// or an up/down counter for a programmed number of steps.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_OP,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [CNT_W-1:0] CMD_CNT,
  output logic [WIDTH-1:0] Q,
  output logic             BUSY,
  output logic             DONE,
  output logic             WRAP
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  op_e              w_cmd_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wrap;
  logic             w_accept;
  logic             w_wrap;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  assign w_cmd_op  = op_e'(CMD_OP);
  assign CMD_READY = (r_state == IDLE) && !RST;
  assign w_accept  = CMD_VALID && CMD_READY;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_cmd_op == OP_CLEAR || w_cmd_op == OP_LOAD) begin
            w_next = EXEC;
          end else if (CMD_CNT == '0) begin
            w_next = DONE_S;
          end else begin
            w_next = COUNT;
          end
        end
      end
      EXEC:    w_next = DONE_S;
      COUNT:   if (r_cnt == CNT_W'(1)) w_next = DONE_S;
      default: w_next = IDLE;
    endcase
  end

  // Per-cell J/K: counting cells toggle when every lower cell is at the
  // carry (all ones, up) or borrow (all zeros, down) value.
  always_comb begin
    jk_e  w_pair;
    logic w_up_en;
    logic w_dn_en;
    w_j = '0;
    w_k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_up_en = 1'b1;
      w_dn_en = 1'b1;
      for (int b = 0; b < i; b++) begin
        w_up_en = w_up_en & Q[b];
        w_dn_en = w_dn_en & ~Q[b];
      end
      w_pair = JK_HOLD;
      if (r_state == EXEC) begin
        if (r_op == OP_CLEAR)     w_pair = JK_RESET;
        else if (r_op == OP_LOAD) w_pair = r_data[i] ? JK_SET : JK_RESET;
      end else if (r_state == COUNT) begin
        if (r_op == OP_UP)        w_pair = w_up_en ? JK_TOGGLE : JK_HOLD;
        else if (r_op == OP_DOWN) w_pair = w_dn_en ? JK_TOGGLE : JK_HOLD;
      end
      {w_j[i], w_k[i]} = w_pair;
    end
  end

  assign w_wrap = (r_state == COUNT) &&
                  (((r_op == OP_UP) && (&Q)) || ((r_op == OP_DOWN) && ~(|Q)));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_op    <= OP_CLEAR;
      r_data  <= '0;
      r_cnt   <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wrap  <= w_wrap;
      if (w_accept) begin
        r_op   <= w_cmd_op;
        r_data <= CMD_DATA;
        r_cnt  <= CMD_CNT;
      end else if (r_state == COUNT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell u_cell (
      .CLK (CLK),
      .RST (RST),
      .J   (w_j[g]),
      .K   (w_k[g]),
      .Q   (Q[g])
    );
  end

  assign BUSY = (r_state != IDLE);
  assign DONE = (r_state == DONE_S);
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed bench for jk_seq_ctrl: each observation packs {Q, BUSY, DONE, WRAP,
// CMD_READY} and is compared against a hand-computed table.
module tb_jk_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CMD_VALID = 1'b0;
  logic       CMD_READY;
  logic [1:0] CMD_OP = 2'b00;
  logic [3:0] CMD_DATA = 4'h0;
  logic [7:0] CMD_CNT = 8'h00;
  logic [3:0] Q;
  logic       BUSY;
  logic       DONE;
  logic       WRAP;

  int n_vec = 0;
  int n_err = 0;

  jk_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_OP    (CMD_OP),
    .CMD_DATA  (CMD_DATA),
    .CMD_CNT   (CMD_CNT),
    .Q         (Q),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .WRAP      (WRAP)
  );

  always #5 CLK = ~CLK;

  // Low nibble of each expected byte: 8=BUSY, 4=DONE, 2=WRAP, 1=CMD_READY.
  function automatic logic [7:0] obs();
    return {Q, BUSY, DONE, WRAP, CMD_READY};
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Presents a command and returns at the negedge following the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [3:0] data, input logic [7:0] cnt);
    int waited = 0;
    CMD_OP = op; CMD_DATA = data; CMD_CNT = cnt; CMD_VALID = 1'b1;
    while (!CMD_READY && waited < 50) begin
      tick();
      waited++;
    end
    if (!CMD_READY) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: CMD_READY stayed %b, want 1", CMD_READY);
      CMD_VALID = 1'b0;
    end else begin
      tick();
      CMD_VALID = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    RST = 1'b1;
    tick();
    tick();
    v = obs();
    n_vec++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL reset_held: got %h want 00", v);
    end
    RST = 1'b0;
    #1;
    v = obs();
    n_vec++;
    if (v !== 8'h01) begin
      n_err++;
      $display("FAIL reset_release: got %h want 01", v);
    end
  endtask

  task automatic test_load();
    logic [7:0] exp_v [3] = '{8'h08, 8'hAC, 8'hA1};
    logic [7:0] v;
    issue(2'b01, 4'hA, 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL load[%0d]: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_up_wrap();
    logic [7:0] exp_v [7] = '{8'hD8, 8'hE8, 8'hF8, 8'h0A, 8'h18, 8'h2C, 8'h21};
    logic [7:0] v;
    issue(2'b01, 4'hD, 8'd0);
    tick();
    tick();
    issue(2'b10, 4'h0, 8'd5);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL up_wrap[%0d]: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_down_wrap();
    logic [7:0] exp_v [5] = '{8'h18, 8'h08, 8'hFA, 8'hEC, 8'hE1};
    logic [7:0] v;
    issue(2'b01, 4'h1, 8'd0);
    tick();
    tick();
    issue(2'b11, 4'h0, 8'd3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL down_wrap[%0d]: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_up_zero();
    logic [7:0] exp_v [2] = '{8'h7C, 8'h71};
    logic [7:0] v;
    issue(2'b01, 4'h7, 8'd0);
    tick();
    tick();
    issue(2'b10, 4'h0, 8'd0);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL up_zero[%0d]: got %h want %h", i, v, exp_v[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] run_v [6] = '{8'h78, 8'h88, 8'h98, 8'hA8, 8'hB8, 8'hC8};
    logic [7:0] new_v [3] = '{8'h08, 8'h3C, 8'h31};
    logic [7:0] v;
    issue(2'b10, 4'h0, 8'd20);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== run_v[i]) begin
        n_err++;
        $display("FAIL abort_run[%0d]: got %h want %h", i, v, run_v[i]);
      end
    end
    RST = 1'b1;
    tick();
    v = obs();
    n_vec++;
    if (v !== 8'h00) begin
      n_err++;
      $display("FAIL abort_in_reset: got %h want 00", v);
    end
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      else #1;
      v = obs();
      n_vec++;
      if (v !== 8'h01) begin
        n_err++;
        $display("FAIL abort_idle[%0d]: got %h want 01", i, v);
      end
    end
    issue(2'b01, 4'h3, 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      v = obs();
      n_vec++;
      if (v !== new_v[i]) begin
        n_err++;
        $display("FAIL abort_reload[%0d]: got %h want %h", i, v, new_v[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_v [8] = '{8'h38, 8'h48, 8'h58, 8'h6C, 8'h61, 8'h68, 8'h0C, 8'h01};
    logic [7:0] v;
    logic       pend = 1'b0;
    int         n_done = 0;
    issue(2'b10, 4'h0, 8'd3);
    CMD_OP = 2'b00; CMD_DATA = 4'h0; CMD_CNT = 8'd0; CMD_VALID = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      if (pend) begin
        CMD_VALID = 1'b0;
        pend = 1'b0;
      end
      v = obs();
      if (DONE === 1'b1) n_done++;
      n_vec++;
      if (v !== exp_v[i]) begin
        n_err++;
        $display("FAIL b2b[%0d]: got %h want %h", i, v, exp_v[i]);
      end
      if (CMD_VALID && CMD_READY) pend = 1'b1;
    end
    CMD_VALID = 1'b0;
    n_vec++;
    if (n_done != 2) begin
      n_err++;
      $display("FAIL b2b_done_count: got %0d want 2", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_up_wrap();
    test_down_wrap();
    test_up_zero();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
